core_run_controller: RTL

- Parametrised run/step controller and result display for the multi-lane issue core.
- Generates the core's clock-enable in four modes: halt, button single-step, slow periodic and full run.
- Samples the low bits of one selected lane's result onto the LED bank and counts committed steps.
- Sits between board I/O (button, LEDs) and the core datapaths; the core runs on the system clock, gated by core_en.

---
 rtl/core_run_controller.sv | 107 ++++++++++
 1 files changed

// File: rtl/core_run_controller.sv
// core_run_controller: run/step clock-enable generator, step counter and lane result LED display.
// Optional HEARTBEAT_EN turns the top LED into a flop that toggles on every core_en pulse.
module core_run_controller #(
  parameter int LANES = 2,
  parameter int DATA_W = 32,
  parameter int LED_W = 8,
  parameter int DIV_COUNT = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SEL_W = (LANES > 1 ? $clog2(LANES) : 1)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    btn,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        lane_sel,
  input  logic [LANES*DATA_W-1:0] lane_result,
  input  logic [LANES-1:0]        lane_valid,
  output logic                    core_en,
  output logic [15:0]             step_count,
  output logic [LED_W-1:0]        led
);
  localparam int DIV_W = $clog2(DIV_COUNT);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef HEARTBEAT_EN
  localparam int DISP_W = LED_W - 1;
`else
  localparam int DISP_W = LED_W;
`endif
  typedef enum logic [1:0] {HALT, STEP, SLOW, RUN} state_t;
  state_t            state;
  logic [DIV_W-1:0]  div;
  logic              sync1, sync2, btn_acc, btn_acc_q;
  logic [DB_W-1:0]   db_cnt;
  logic              step_req, mode_chg, div_end;
  logic              sel_hit, sel_valid;
  logic [DISP_W-1:0] sel_data, disp;
  logic              unused_ok;
  assign unused_ok = ^lane_result;
  assign step_req = btn_acc & ~btn_acc_q;
  assign mode_chg = mode != state;
  assign div_end = div == DIV_W'(DIV_COUNT - 1);
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      btn_acc <= 1'b0;
      btn_acc_q <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      btn_acc_q <= btn_acc;
      if (sync2 == btn_acc)
        db_cnt <= '0;
      else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_acc <= sync2;
        db_cnt <= '0;
      end else
        db_cnt <= db_cnt + 1'b1;
    end
  end
  // a mode change in flight suppresses every pulse source, including a coincident step_req
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= HALT;
      div <= '0;
      core_en <= 1'b0;
    end else begin
      state <= state_t'(mode);
      div <= (mode_chg || state != SLOW || div_end) ? '0 : div + 1'b1;
      core_en <= !mode_chg && (state == RUN || (state == STEP && step_req) || (state == SLOW && div_end));
    end
  end
  always_comb begin
    sel_hit = 1'b0;
    sel_valid = 1'b0;
    sel_data = '0;
    for (int i = 0; i < LANES; i++)
      if (lane_sel == SEL_W'(i)) begin
        sel_hit = 1'b1;
        sel_valid = lane_valid[i];
        sel_data = lane_result[i*DATA_W +: DISP_W];
      end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      step_count <= '0;
      disp <= '0;
    end else begin
      step_count <= step_count + {15'd0, core_en};
      if (core_en)
        disp <= !sel_hit ? '0 : sel_valid ? sel_data : disp;
    end
  end
`ifdef HEARTBEAT_EN
  logic hb;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      hb <= 1'b0;
    else
      hb <= hb ^ core_en;
  end
  assign led = {hb, disp};
`else
  assign led = disp;
`endif
endmodule
